// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle control FSM for the nRisc 8-bit core.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB over the shared datapath,
// decodes opcode = instruction[7:5] and drives every datapath enable/select.
// Memory accesses (FETCH, MEM) stall until mem_ready. Counts retired
// instructions in a wrapping counter.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   instruction[7:0]   IR contents (valid from DECODE onward)
//   alu_zero           ALU zero flag (used by beq in EXEC)
//   mem_ready          memory completes the current access this cycle
//   pc_write, pc_src   PC load enable / source (00 PC+1, 01 PC+1+imm, 10 imm)
//   iord               memory address source (0 PC, 1 ALU result)
//   mem_read/mem_write memory requests
//   ir_write           IR load enable
//   reg_write          register bank write enable
//   mem_to_reg         write-back source (1 memory, 0 ALU)
//   alu_src, alu_op    ALU B source / operation (00 add, 01 sub, 10 funct, 11 imm)
//   halted             FSM parked in HALT
//   state[2:0]         current state (debug)
//   instr_count        retired-instruction counter
module controle_multiciclo #(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter logic [2:0]  RTYPE_OPCODE = 3'b011,
  parameter logic [2:0]  HALT_OPCODE  = 3'b111
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           instruction,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [2:0] OpStore = 3'b000;
  localparam logic [2:0] OpLa    = 3'b001;
  localparam logic [2:0] OpLoad  = 3'b010;
  localparam logic [2:0] OpAddi  = 3'b100;
  localparam logic [2:0] OpBeq   = 3'b101;
  localparam logic [2:0] OpJ     = 3'b110;

  state_e               r_state;
  state_e               w_state_next;
  logic [CNT_WIDTH-1:0] r_instr_count;
  logic                 w_retire;
  logic [2:0]           w_opcode;
  logic                 w_unused_instr;

  assign w_opcode       = instruction[7:5];
  // Operand/funct bits are consumed by the datapath, not by the controller.
  assign w_unused_instr = ^instruction[4:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StFetch;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    halted       = 1'b0;

    case (r_state)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = StDecode;
        end
      end

      StDecode: begin
        if (w_opcode == OpJ) begin
          pc_write     = 1'b1;
          pc_src       = 2'b10;
          w_retire     = 1'b1;
          w_state_next = StFetch;
        end else if (w_opcode == HALT_OPCODE) begin
          w_state_next = StHalt;
        end else begin
          w_state_next = StExec;
        end
      end

      StExec: begin
        w_state_next = StFetch;
        if (w_opcode == RTYPE_OPCODE) begin
          alu_op       = 2'b10;
          w_state_next = StWb;
        end else begin
          case (w_opcode)
            OpStore, OpLoad: begin
              alu_src      = 1'b1;
              w_state_next = StMem;
            end
            OpAddi: begin
              alu_src      = 1'b1;
              w_state_next = StWb;
            end
            OpLa: begin
              alu_src      = 1'b1;
              alu_op       = 2'b11;
              w_state_next = StWb;
            end
            OpBeq: begin
              alu_op   = 2'b01;
              w_retire = 1'b1;
              if (alu_zero) begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
              end
            end
            default: w_state_next = StFetch;
          endcase
        end
      end

      StMem: begin
        iord      = 1'b1;
        mem_read  = (w_opcode == OpLoad);
        mem_write = (w_opcode == OpStore);
        if (mem_ready) begin
          if (w_opcode == OpLoad) begin
            w_state_next = StWb;
          end else begin
            w_retire     = (w_opcode == OpStore);
            w_state_next = StFetch;
          end
        end
      end

      StWb: begin
        reg_write    = 1'b1;
        mem_to_reg   = (w_opcode == OpLoad);
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end

      StHalt: begin
        halted = 1'b1;
      end

      // Unused encodings recover to FETCH.
      default: w_state_next = StFetch;
    endcase

    // Reset masks every control output, whatever the current state.
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      halted     = 1'b0;
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo. For every instruction the bench
// builds the expected per-cycle control trace from the instruction-level
// rules (opcode, branch outcome, number of memory wait cycles) and compares
// it cycle by cycle; a counter model tracks retirements modulo 256.
module tb_controle_multiciclo;

  logic       clock;
  logic       reset;
  logic [7:0] instruction;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       halted;
  logic [2:0] state;
  logic [7:0] instr_count;

  controle_multiciclo dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] v;
    logic        rdy;
  } exp_t;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned m_count = 0;

  logic [15:0] obs;
  assign obs = {state, pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                mem_to_reg, alu_src, alu_op, halted};

  function automatic logic [15:0] pk(input logic [2:0] st, input logic pw,
                                     input logic [1:0] ps, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic m2r, input logic as_, input logic [1:0] ao,
                                     input logic h);
    return {st, pw, ps, io, mr, mw, irw, rw, m2r, as_, ao, h};
  endfunction

  // Must be entered at posedge+1 with the DUT in FETCH; leaves the same way
  // (or in HALT for the halt opcode).
  task automatic run_instr(input string name, input logic [7:0] instr, input logic zero,
                           input int fw, input int mw);
    exp_t        q[$];
    logic [2:0]  op;
    logic        rnd;
    op          = instr[7:5];
    instruction = instr;
    alu_zero    = zero;
    for (int i = 0; i < fw; i++) q.push_back('{pk(0,0,0,0,1,0,0,0,0,0,0,0), 1'b0});
    q.push_back('{pk(0,1,2'b00,0,1,0,1,0,0,0,0,0), 1'b1});
    rnd = 1'($urandom);
    if (op == 3'b110) q.push_back('{pk(1,1,2'b10,0,0,0,0,0,0,0,0,0), rnd});
    else q.push_back('{pk(1,0,0,0,0,0,0,0,0,0,0,0), rnd});
    if (op != 3'b110 && op != 3'b111) begin
      rnd = 1'($urandom);
      case (op)
        3'b000, 3'b010, 3'b100: q.push_back('{pk(2,0,0,0,0,0,0,0,0,1,2'b00,0), rnd});
        3'b001:                 q.push_back('{pk(2,0,0,0,0,0,0,0,0,1,2'b11,0), rnd});
        3'b011:                 q.push_back('{pk(2,0,0,0,0,0,0,0,0,0,2'b10,0), rnd});
        default: q.push_back('{pk(2,zero,zero ? 2'b01 : 2'b00,0,0,0,0,0,0,0,2'b01,0), rnd});
      endcase
      if (op == 3'b000 || op == 3'b010) begin
        for (int i = 0; i <= mw; i++)
          q.push_back('{pk(3,0,0,1,op == 3'b010,op == 3'b000,0,0,0,0,0,0), i == mw});
      end
      if (op != 3'b000 && op != 3'b101)
        q.push_back('{pk(4,0,0,0,0,0,0,1,op == 3'b010,0,0,0), 1'($urandom)});
    end
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      @(negedge clock);
      vectors++;
      if (obs !== q[i].v) begin
        errors++;
        $display("FAIL %s instr=%h cycle %0d: outputs got %h expected %h",
                 name, instr, i, obs, q[i].v);
      end
      vectors++;
      if ((mem_read && mem_write) || (pc_write && reg_write)) begin
        errors++;
        $display("FAIL %s exclusive cycle %0d: mr/mw/pw/rw got %b%b%b%b expected no pair",
                 name, i, mem_read, mem_write, pc_write, reg_write);
      end
      @(posedge clock);
      #1;
    end
    if (op != 3'b111) begin
      m_count = (m_count + 1) % 256;
      vectors++;
      if (instr_count !== 8'(m_count) || state !== 3'd0) begin
        errors++;
        $display("FAIL %s retire: count/state got %0d/%0d expected %0d/0",
                 name, instr_count, state, m_count);
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    vectors++;
    if (obs !== 16'h0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs/count got %h/%0d expected 0000/0", obs, instr_count);
    end
    reset     = 1'b0;
    mem_ready = 1'b0;
    m_count   = 0;
    #1;
    vectors++;
    if (obs !== pk(0,0,0,0,1,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_release: outputs got %h expected %h", obs,
               pk(0,0,0,0,1,0,0,0,0,0,0,0));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_addi;
    run_instr("addi", 8'h85, 1'b0, 0, 0);
  endtask

  task automatic test_load_wait;
    run_instr("load_wait", 8'h43, 1'b0, 0, 3);
    run_instr("load_fetch_wait", 8'h4A, 1'b1, 2, 1);
  endtask

  task automatic test_beq;
    run_instr("beq_taken", 8'hA4, 1'b1, 0, 0);
    run_instr("beq_not_taken", 8'hA4, 1'b0, 0, 0);
  endtask

  task automatic test_jump;
    run_instr("jump", 8'hC7, 1'b0, 0, 0);
  endtask

  task automatic test_halt;
    int unsigned saved;
    saved = m_count;
    run_instr("halt_entry", 8'hE0 | 8'($urandom_range(0, 31)), 1'b0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
      @(negedge clock);
      vectors++;
      if (obs !== pk(5,0,0,0,0,0,0,0,0,0,0,1) || instr_count !== 8'(saved)) begin
        errors++;
        $display("FAIL halt_park cycle %0d: outputs/count got %h/%0d expected %h/%0d",
                 i, obs, instr_count, pk(5,0,0,0,0,0,0,0,0,0,0,1), saved);
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset_mask: halted got %b expected 0", halted);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (state !== 3'd0 || obs !== 16'h0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL halt_reset: state/outputs/count got %0d/%h/%0d expected 0/0000/0",
               state, obs, instr_count);
    end
    reset     = 1'b0;
    mem_ready = 1'b0;
    m_count   = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_wrap_and_mem_reset;
    test_reset();
    for (int i = 0; i < 261; i++) run_instr("wrap_addi", 8'h80 | 8'(i % 32), 1'b0, 0, 0);
    // Store, interrupted by reset while waiting in MEM.
    instruction = 8'h15;
    mem_ready   = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if (obs !== pk(3,0,0,1,0,1,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL mem_stall: outputs got %h expected %h", obs, pk(3,0,0,1,0,1,0,0,0,0,0,0));
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== {3'd3, 13'h0}) begin
      errors++;
      $display("FAIL mem_reset_mask: outputs got %h expected %h", obs, {3'd3, 13'h0});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (obs !== pk(0,0,0,0,1,0,0,0,0,0,0,0) || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL mem_reset_fetch: outputs/count got %h/%0d expected %h/0",
               obs, instr_count, pk(0,0,0,0,1,0,0,0,0,0,0,0));
    end
    m_count = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random;
    logic [2:0] op;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 6));
      run_instr("random", {op, 5'($urandom)}, 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 8'h00;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_beq();
    test_jump();
    test_halt();
    test_wrap_and_mem_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
